// File: rtl/nn_inference_scheduler.sv
// Purpose : double-buffered input store and sequencer feeding layer 1, one inference in flight.
// Latency : first m_x_valid 2 cycles after the last input word; result/intr 1 cycle after nn_result_valid.
// Backpress: s_in_ready drops while the bank being written is still full (both banks occupied).
//
// Ports:
//   s_axi_aclk, reset          - clock, synchronous active-high reset
//   s_in_data/valid/ready      - input word stream into the two-bank store
//   m_x_data/valid             - registered gap-free burst of one vector into layer 1
//   nn_result/nn_result_valid  - max-finder result, only accepted while waiting for it
//   result, inference_count    - last latched result and completed-inference counter
//   intr, intr_clr             - sticky interrupt (completion or timeout) and its clear pulse
//   busy, timeout_err          - not-idle indicator and sticky watchdog error
module nn_inference_scheduler #(
   parameter int DATA_WIDTH     = 16,
   parameter int NUM_INPUTS     = 784,
   parameter int RESULT_WIDTH   = 32,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                    s_axi_aclk,
   input  logic                    reset,
   input  logic [DATA_WIDTH-1:0]   s_in_data,
   input  logic                    s_in_valid,
   output logic                    s_in_ready,
   output logic [DATA_WIDTH-1:0]   m_x_data,
   output logic                    m_x_valid,
   input  logic [RESULT_WIDTH-1:0] nn_result,
   input  logic                    nn_result_valid,
   output logic [RESULT_WIDTH-1:0] result,
   output logic                    intr,
   input  logic                    intr_clr,
   output logic                    busy,
   output logic                    timeout_err,
   output logic [31:0]             inference_count
);

   localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [1:0]              bank_full_q, bank_full_d;
   logic                    wr_bank_q, wr_bank_d;
   logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
   logic                    rd_bank_q, rd_bank_d;
   logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
   logic [WD_W-1:0]         wd_q, wd_d;
   logic                    m_x_valid_q, m_x_valid_d;
   logic [DATA_WIDTH-1:0]   m_x_data_q;
   logic [RESULT_WIDTH-1:0] result_q, result_d;
   logic                    intr_q, intr_d;
   logic                    timeout_err_q, timeout_err_d;
   logic [31:0]             count_q, count_d;
   logic                    intr_set;
   logic                    rd_en;
   logic                    wr_fire;

   logic [DATA_WIDTH-1:0]   mem_q [2][NUM_INPUTS];

   assign s_in_ready      = ~bank_full_q[wr_bank_q];
   assign wr_fire         = s_in_valid & s_in_ready;
   assign m_x_data        = m_x_data_q;
   assign m_x_valid       = m_x_valid_q;
   assign result          = result_q;
   assign intr            = intr_q;
   assign busy            = (state_q != S_IDLE);
   assign timeout_err     = timeout_err_q;
   assign inference_count = count_q;

   // Storage has no reset: stale words are unreachable once the full flags clear.
   always_ff @(posedge s_axi_aclk) begin
      if (wr_fire) mem_q[wr_bank_q][wr_cnt_q] <= s_in_data;
   end

   // Synchronous read port doubles as the m_x_data output register.
   always_ff @(posedge s_axi_aclk) begin
      if (reset)      m_x_data_q <= '0;
      else if (rd_en) m_x_data_q <= mem_q[rd_bank_q][rd_cnt_q];
   end

   always_ff @(posedge s_axi_aclk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         bank_full_q   <= '0;
         wr_bank_q     <= 1'b0;
         wr_cnt_q      <= '0;
         rd_bank_q     <= 1'b0;
         rd_cnt_q      <= '0;
         wd_q          <= '0;
         m_x_valid_q   <= 1'b0;
         result_q      <= '0;
         intr_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         bank_full_q   <= bank_full_d;
         wr_bank_q     <= wr_bank_d;
         wr_cnt_q      <= wr_cnt_d;
         rd_bank_q     <= rd_bank_d;
         rd_cnt_q      <= rd_cnt_d;
         wd_q          <= wd_d;
         m_x_valid_q   <= m_x_valid_d;
         result_q      <= result_d;
         intr_q        <= intr_d;
         timeout_err_q <= timeout_err_d;
         count_q       <= count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      bank_full_d   = bank_full_q;
      wr_bank_d     = wr_bank_q;
      wr_cnt_d      = wr_cnt_q;
      rd_bank_d     = rd_bank_q;
      rd_cnt_d      = rd_cnt_q;
      wd_d          = wd_q;
      m_x_valid_d   = 1'b0;
      result_d      = result_q;
      timeout_err_d = timeout_err_q;
      count_d       = count_q;
      intr_set      = 1'b0;
      rd_en         = 1'b0;

      // Fill side runs independently of the FSM so the other bank loads during a burst.
      if (wr_fire) begin
         if (wr_cnt_q == LAST_IDX) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
            wr_cnt_d               = '0;
         end else begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (bank_full_q[rd_bank_q]) begin
               state_d  = S_ISSUE;
               rd_cnt_d = '0;
            end
         end
         S_ISSUE: begin
            rd_en       = 1'b1;
            m_x_valid_d = 1'b1;
            if (rd_cnt_q == LAST_IDX) begin
               // A filling bank is never the full bank being released, so this cannot
               // collide with the set above.
               bank_full_d[rd_bank_q] = 1'b0;
               rd_bank_d              = ~rd_bank_q;
               rd_cnt_d               = '0;
               wd_d                   = '0;
               state_d                = S_WAIT;
            end else begin
               rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
         end
         S_WAIT: begin
            // A real result takes precedence over a watchdog expiry in the same cycle.
            if (nn_result_valid) begin
               result_d = nn_result;
               count_d  = count_q + 32'd1;
               intr_set = 1'b1;
               state_d  = S_IDLE;
            end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST)) begin
               timeout_err_d = 1'b1;
               intr_set      = 1'b1;
               state_d       = S_IDLE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Set beats clear when both happen together.
      intr_d = (intr_q & ~intr_clr) | intr_set;
   end

endmodule

// File: tb/tb_nn_inference_scheduler.sv
module tb_nn_inference_scheduler;

   localparam int DW = 16;
   localparam int RW = 32;

   logic          clk;
   logic          reset;
   logic [DW-1:0] s_in_data;
   logic          s_in_valid;
   logic          s_in_ready;
   logic [DW-1:0] m_x_data;
   logic          m_x_valid;
   logic [RW-1:0] nn_result;
   logic          nn_result_valid;
   logic [RW-1:0] result;
   logic          intr;
   logic          intr_clr;
   logic          busy;
   logic          timeout_err;
   logic [31:0]   inference_count;

   int tests = 0;
   int fails = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mon_exp;

   nn_inference_scheduler #(
      .DATA_WIDTH(DW), .NUM_INPUTS(4), .RESULT_WIDTH(RW), .TIMEOUT_CYCLES(20)
   ) dut (
      .s_axi_aclk(clk), .reset(reset),
      .s_in_data(s_in_data), .s_in_valid(s_in_valid), .s_in_ready(s_in_ready),
      .m_x_data(m_x_data), .m_x_valid(m_x_valid),
      .nn_result(nn_result), .nn_result_valid(nn_result_valid),
      .result(result), .intr(intr), .intr_clr(intr_clr), .busy(busy),
      .timeout_err(timeout_err), .inference_count(inference_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Scoreboard monitor: every presented layer-1 word must match the next queued input.
   always @(negedge clk) begin
      if (m_x_valid === 1'b1) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL x_unexpected: actual=%0h required=none", m_x_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (m_x_data !== mon_exp) begin
               fails++;
               $display("FAIL x_data: actual=%0h required=%0h", m_x_data, mon_exp);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL time_limit: actual=running required=finished");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves s_in_valid asserted; caller decides what follows the last word.
   task automatic send_seq(input int first, input int n);
      for (int i = 0; i < n; i++) begin
         s_in_valid = 1'b1;
         s_in_data  = DW'(first + i);
         exp_q.push_back(DW'(first + i));
         chk("in_ready", 64'(s_in_ready), 64'd1);
         tick();
      end
   endtask

   // Called one cycle after the last input handshake: expects ISSUE next,
   // then exactly four consecutive valid cycles.
   task automatic check_burst(input string nm);
      tick();
      chk({nm, "_issue_busy"}, 64'(busy), 64'd1);
      chk({nm, "_pre_valid"}, 64'(m_x_valid), 64'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk({nm, "_burst_valid"}, 64'(m_x_valid), 64'd1);
      end
      tick();
      chk({nm, "_post_valid"}, 64'(m_x_valid), 64'd0);
      chk({nm, "_wait_busy"}, 64'(busy), 64'd1);
   endtask

   task automatic pulse_result(input logic [RW-1:0] v, input logic clr);
      nn_result       = v;
      nn_result_valid = 1'b1;
      intr_clr        = clr;
      tick();
      nn_result_valid = 1'b0;
      intr_clr        = 1'b0;
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_ready"}, 64'(s_in_ready), 64'd1);
      chk({nm, "_xvalid"}, 64'(m_x_valid), 64'd0);
      chk({nm, "_xdata"}, 64'(m_x_data), 64'd0);
      chk({nm, "_result"}, 64'(result), 64'd0);
      chk({nm, "_intr"}, 64'(intr), 64'd0);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_tmo"}, 64'(timeout_err), 64'd0);
      chk({nm, "_count"}, 64'(inference_count), 64'd0);
   endtask

   initial begin
      reset = 1'b1; s_in_valid = 1'b0; s_in_data = '0;
      nn_result = '0; nn_result_valid = 1'b0; intr_clr = 1'b0;
      tick(); tick();
      chk_reset_vals("rst");
      reset = 1'b0;
      tick();

      // Single vector 1..4, then result 7.
      send_seq(1, 4);
      s_in_valid = 1'b0;
      check_burst("single");
      pulse_result(32'd7, 1'b0);
      chk("single_result", 64'(result), 64'd7);
      chk("single_intr", 64'(intr), 64'd1);
      chk("single_count", 64'(inference_count), 64'd1);
      chk("single_busy", 64'(busy), 64'd0);

      // Lone clear pulse.
      intr_clr = 1'b1; tick(); intr_clr = 1'b0;
      chk("clr_lone_intr", 64'(intr), 64'd0);

      // Double buffer: 8 words back-to-back, then hold valid with a third vector.
      send_seq(1, 8);
      s_in_data = 16'd9;
      exp_q.push_back(16'd9);
      chk("db_both_full_ready", 64'(s_in_ready), 64'd0);
      tick();
      chk("db_released_ready", 64'(s_in_ready), 64'd1);
      tick();
      for (int v = 10; v <= 12; v++) begin
         s_in_data = DW'(v);
         exp_q.push_back(DW'(v));
         tick();
      end
      s_in_valid = 1'b0;

      // Completion coinciding with intr_clr: set wins.
      pulse_result(32'h21, 1'b1);
      chk("db_clr_collide_intr", 64'(intr), 64'd1);
      chk("db_result1", 64'(result), 64'h21);
      chk("db_count1", 64'(inference_count), 64'd2);
      chk("db_idle_busy", 64'(busy), 64'd0);
      tick();
      chk("db_issue2_busy", 64'(busy), 64'd1);
      chk("db_issue2_pre_valid", 64'(m_x_valid), 64'd0);
      tick();
      chk("db_burst2_valid", 64'(m_x_valid), 64'd1);
      chk("db_burst2_ready", 64'(s_in_ready), 64'd0);
      tick(); tick(); tick(); tick();
      chk("db_burst2_end_valid", 64'(m_x_valid), 64'd0);
      chk("db_burst2_end_ready", 64'(s_in_ready), 64'd1);
      pulse_result(32'h22, 1'b0);
      chk("db_result2", 64'(result), 64'h22);
      chk("db_count2", 64'(inference_count), 64'd3);
      chk("db_intr2", 64'(intr), 64'd1);

      // Third vector issues automatically; clear intr, then let the watchdog expire.
      intr_clr = 1'b1; tick(); intr_clr = 1'b0;
      chk("tmo_clr_intr", 64'(intr), 64'd0);
      chk("tmo_issue_busy", 64'(busy), 64'd1);
      repeat (23) tick();
      chk("tmo_before_err", 64'(timeout_err), 64'd0);
      chk("tmo_before_busy", 64'(busy), 64'd1);
      tick();
      chk("tmo_err", 64'(timeout_err), 64'd1);
      chk("tmo_intr", 64'(intr), 64'd1);
      chk("tmo_busy", 64'(busy), 64'd0);
      chk("tmo_count", 64'(inference_count), 64'd3);
      chk("tmo_result", 64'(result), 64'h22);

      // Late / spurious result in IDLE is ignored.
      intr_clr = 1'b1; tick(); intr_clr = 1'b0;
      chk("spur_clr_intr", 64'(intr), 64'd0);
      pulse_result(32'h99, 1'b0);
      chk("spur_result", 64'(result), 64'h22);
      chk("spur_intr", 64'(intr), 64'd0);
      chk("spur_count", 64'(inference_count), 64'd3);
      chk("spur_busy", 64'(busy), 64'd0);
      chk("spur_tmo_sticky", 64'(timeout_err), 64'd1);

      // Reset after two of four words have been issued.
      send_seq(16'h31, 4);
      s_in_valid = 1'b0;
      tick();
      chk("rmid_issue_busy", 64'(busy), 64'd1);
      tick();
      chk("rmid_word1_valid", 64'(m_x_valid), 64'd1);
      tick();
      chk("rmid_word2_valid", 64'(m_x_valid), 64'd1);
      reset = 1'b1;
      tick();
      chk_reset_vals("rmid");
      exp_q.delete();
      reset = 1'b0;

      // Fresh vector after reset.
      send_seq(16'h41, 4);
      s_in_valid = 1'b0;
      check_burst("post_rst");
      pulse_result(32'h55, 1'b0);
      chk("post_rst_result", 64'(result), 64'h55);
      chk("post_rst_count", 64'(inference_count), 64'd1);
      chk("post_rst_intr", 64'(intr), 64'd1);
      tick();
      chk("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
